// File: rtl/bridge_pkg.sv
// Shared definitions for the SRAM-to-BRAM request bridge.
package bridge_pkg;

    // CPU access size encodings carried on the size port.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Default number of buffered responses.
    localparam int RESP_DEPTH_DEF = 2;

    // Width of one response entry (read data, or zero for writes).
    localparam int RESP_W = 32;

endpackage

// File: rtl/sram_bram_bridge_resp_fifo.sv
// Response FIFO: holds completed BRAM responses until the CPU takes them.
module resp_fifo
    import bridge_pkg::*;
#(
    parameter  int DEPTH = RESP_DEPTH_DEF,
    parameter  int WIDTH = RESP_W,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Pointer advance with wrap at the (possibly non-power-of-two) depth.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PW'(DEPTH - 1)) begin
            n = {PW{1'b0}};
        end else begin
            n = p + PW'(1);
        end
        return n;
    endfunction

    // Entry storage: write the tail slot on push.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop keeps the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (i_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/sram_bram_bridge.sv
// Bridge between the CPU SRAM-like port and a one-cycle-latency block RAM.
// Issue is throttled so that in-flight plus buffered responses never exceed
// the response FIFO depth; the youngest response bypasses the FIFO when the
// CPU can take it immediately.
module sram_bram_bridge
    import bridge_pkg::*;
#(
    parameter  int ADDR_WIDTH = 16,
    parameter  int DATA_WIDTH = 32,
    parameter  int RESP_DEPTH = RESP_DEPTH_DEF,
    localparam int CW         = $clog2(RESP_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req,
    input  logic                  wr,
    input  logic [1:0]            size,
    input  logic [3:0]            wstrb,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  addr_ok,
    output logic                  data_ok,
    input  logic                  data_ready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  bram_en,
    output logic [3:0]            bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_wdata,
    input  logic [DATA_WIDTH-1:0] bram_rdata
);

    logic                  r_pend;
    logic                  r_pend_wr;
    logic [CW-1:0]         w_count;
    logic [DATA_WIDTH-1:0] w_head;
    logic [DATA_WIDTH-1:0] w_bypass;
    logic [CW:0]           w_occ;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_unused;

    // Alignment and strobe consistency are the CPU's responsibility.
    assign w_unused = ^{size, addr[1:0], addr[31:ADDR_WIDTH+2]};

    // Issue side: accept only while a response slot is guaranteed.
    always_comb begin
        w_occ      = {1'b0, w_count} + {{CW{1'b0}}, r_pend};
        addr_ok    = 1'b0;
        bram_we    = 4'b0000;
        bram_addr  = addr[ADDR_WIDTH+1:2];
        bram_wdata = wdata;
        if (req && (w_occ < (CW+1)'(RESP_DEPTH))) begin
            addr_ok = 1'b1;
        end else begin
            addr_ok = 1'b0;
        end
        if (addr_ok && wr) begin
            bram_we = wstrb;
        end else begin
            bram_we = 4'b0000;
        end
        bram_en = addr_ok;
    end

    // Response side: FIFO head has priority, else the in-flight bypass.
    always_comb begin
        rdata    = {DATA_WIDTH{1'b0}};
        data_ok  = 1'b0;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        if (r_pend_wr) begin
            w_bypass = {DATA_WIDTH{1'b0}};
        end else begin
            w_bypass = bram_rdata;
        end
        if (w_count != {CW{1'b0}}) begin
            data_ok = 1'b1;
            rdata   = w_head;
            w_pop   = data_ready;
            w_push  = r_pend;
        end else if (r_pend) begin
            data_ok = 1'b1;
            rdata   = w_bypass;
            w_push  = !data_ready;
        end else begin
            data_ok = 1'b0;
            rdata   = {DATA_WIDTH{1'b0}};
        end
    end

    // In-flight tracker: one BRAM access completes the cycle after issue.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pend    <= 1'b0;
            r_pend_wr <= 1'b0;
        end else if (addr_ok) begin
            r_pend    <= 1'b1;
            r_pend_wr <= wr;
        end else begin
            r_pend    <= 1'b0;
            r_pend_wr <= 1'b0;
        end
    end

    resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_resp_fifo (
        .i_clk   (clk),
        .i_rst_n (resetn),
        .i_push  (w_push),
        .i_data  (w_bypass),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_sram_bram_bridge.sv
// Self-checking bench for sram_bram_bridge: directed scenarios plus random
// traffic, checked against a transaction-level model (word array + queue of
// outstanding responses).
module tb_sram_bram_bridge;

    localparam int AW    = 16;
    localparam int DEPTH = 2;

    logic        clk;
    logic        resetn;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic        data_ready;
    logic [31:0] rdata;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [AW-1:0] bram_addr;
    logic [31:0] bram_wdata;
    logic [31:0] bram_rdata;

    sram_bram_bridge #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (32),
        .RESP_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .wr         (wr),
        .size       (size),
        .wstrb      (wstrb),
        .addr       (addr),
        .wdata      (wdata),
        .addr_ok    (addr_ok),
        .data_ok    (data_ok),
        .data_ready (data_ready),
        .rdata      (rdata),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_rdata (bram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment BRAM: one-cycle read latency, output held while idle.
    logic [31:0] bmem [256];
    logic        tb_load;
    logic [31:0] ref_mem [256];

    always @(posedge clk) begin
        if (tb_load) begin
            for (int i = 0; i < 256; i++) bmem[i] <= ref_mem[i];
            bram_rdata <= 32'h0;
        end else if (bram_en) begin
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) bmem[bram_addr[7:0]][8*b +: 8] <= bram_wdata[8*b +: 8];
            bram_rdata <= bmem[bram_addr[7:0]];
        end
    end

    // Reference model state.
    typedef struct { logic [31:0] d; int t; } resp_t;
    resp_t q[$];
    int    cyc;
    int    n_checks;
    int    n_errors;
    logic  obs_addr_ok;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One CPU cycle: drive at negedge, check, advance model, cross posedge.
    task automatic step(input logic r, input logic w, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] d, input logic rdy);
        logic        e_ok;
        logic        e_dok;
        logic [31:0] word;
        resp_t       nr;
        req = r; wr = w; wstrb = s; addr = a; wdata = d; data_ready = rdy;
        size = (s == 4'hF) ? 2'd2 : ((s == 4'h3 || s == 4'hC) ? 2'd1 : 2'd0);
        #1;
        e_ok  = r && (q.size() < DEPTH);
        e_dok = (q.size() > 0) && (q[0].t < cyc);
        obs_addr_ok = addr_ok;
        check_val("addr_ok", {31'h0, addr_ok}, {31'h0, e_ok});
        check_val("bram_en", {31'h0, bram_en}, {31'h0, e_ok});
        check_val("bram_we", {28'h0, bram_we}, {28'h0, (e_ok && w) ? s : 4'h0});
        check_val("bram_addr", {16'h0, bram_addr}, {16'h0, a[17:2]});
        check_val("bram_wdata", bram_wdata, d);
        check_val("data_ok", {31'h0, data_ok}, {31'h0, e_dok});
        if (e_dok) check_val("rdata", rdata, q[0].d);
        if (e_dok && rdy) void'(q.pop_front());
        if (e_ok) begin
            word = ref_mem[a[9:2]];
            nr.d = w ? 32'h0 : word;
            nr.t = cyc;
            q.push_back(nr);
            for (int b = 0; b < 4; b++)
                if (w && s[b]) word[8*b +: 8] = d[8*b +: 8];
            ref_mem[a[9:2]] = word;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] ra;
        logic [3:0]  rs;
        logic [1:0]  off;
        n_checks = 0; n_errors = 0; cyc = 0;
        req = 1'b0; wr = 1'b0; size = 2'd0; wstrb = 4'h0; addr = 32'h0;
        wdata = 32'h0; data_ready = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
        ref_mem[8'h10] = 32'hDEADBEEF;
        resetn = 1'b0; tb_load = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_data_ok", {31'h0, data_ok}, 32'h0);
        check_val("rst_rdata", rdata, 32'h0);
        check_val("rst_addr_ok", {31'h0, addr_ok}, 32'h0);
        check_val("rst_bram_en", {31'h0, bram_en}, 32'h0);
        check_val("rst_bram_we", {28'h0, bram_we}, 32'h0);
        tb_load = 1'b0; resetn = 1'b1;
        @(negedge clk);

        // Single read of word 0x10.
        step(1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 1'b1);
        check_val("single_dok", {31'h0, data_ok}, 32'h1);
        check_val("single_rdata", rdata, 32'hDEADBEEF);
        // Byte write to 0x43 then read back the merged word.
        step(1'b1, 1'b1, 4'b1000, 32'h43, 32'hAB000000, 1'b1);
        check_val("bwr_rdata", rdata, 32'h0);
        step(1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 1'b1);
        check_val("raw_rdata", rdata, 32'hABADBEEF);
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);

        // Back-to-back reads of words 0..7.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'h0, 32'(i * 4), 32'h0, 1'b1);
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        check_val("b2b_drained", 32'(q.size()), 32'h0);

        // Stall: two accepted, then blocked until the first pop.
        step(1'b1, 1'b0, 4'h0, 32'h80, 32'h0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 32'h84, 32'h0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 32'h88, 32'h0, 1'b0);
        check_val("stall_blk0", {31'h0, obs_addr_ok}, 32'h0);
        step(1'b1, 1'b0, 4'h0, 32'h88, 32'h0, 1'b0);
        check_val("stall_blk1", {31'h0, obs_addr_ok}, 32'h0);
        step(1'b1, 1'b0, 4'h0, 32'h88, 32'h0, 1'b1);
        check_val("stall_blk2", {31'h0, obs_addr_ok}, 32'h0);
        step(1'b1, 1'b0, 4'h0, 32'h88, 32'h0, 1'b1);
        check_val("stall_resume", {31'h0, obs_addr_ok}, 32'h1);
        step(1'b1, 1'b0, 4'h0, 32'h8C, 32'h0, 1'b1);
        check_val("stall_resume2", {31'h0, obs_addr_ok}, 32'h1);
        // Hold the head one cycle, then push and pop together.
        step(1'b1, 1'b0, 4'h0, 32'h90, 32'h0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 32'h94, 32'h0, 1'b1);
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);

        // Reset with two responses buffered.
        step(1'b1, 1'b0, 4'h0, 32'hA0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 32'hA4, 32'h0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        resetn = 1'b0;
        #1;
        check_val("mid_rst_dok", {31'h0, data_ok}, 32'h0);
        check_val("mid_rst_rdata", rdata, 32'h0);
        q.delete();
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            ra  = {22'h0, 8'($urandom_range(0, 15)), 2'b00};
            off = 2'($urandom);
            case ($urandom_range(0, 2))
                0:       rs = 4'b0001 << off;
                1:       begin off = {off[1], 1'b0}; rs = 4'b0011 << off; end
                default: begin off = 2'd0; rs = 4'hF; end
            endcase
            step(($urandom % 4) != 0, ($urandom % 3) == 0, rs, ra | {30'h0, off},
                 $urandom, ($urandom % 3) != 0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        check_val("final_drained", 32'(q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_bram_bridge.md
# sram_bram_bridge

Request-side bridge between the CPU's SRAM-like memory port (req/addr_ok, data_ok/rdata) and a single-port synchronous block RAM with one-cycle read latency and per-byte write enables. One instance sits in front of the instruction RAM and one in front of the data RAM. It issues at most one BRAM access per cycle. It tracks the in-flight access and buffers responses in a small FIFO, so the CPU can stall response consumption without losing data.

## Interface
Parameters:
- ADDR_WIDTH, 16, BRAM word-address width.
- DATA_WIDTH, 32, data width. Fixed at 32 in this design.
- RESP_DEPTH, 2, response FIFO entries. Minimum 2.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- req  in  1  CPU request valid.
- wr  in  1  1 = write, 0 = read.
- size  in  2  access size: 0 = byte, 1 = half, 2 = word.
- wstrb  in  4  byte strobes for writes.
- addr  in  32  byte address.
- wdata  in  32  write data.
- addr_ok  out  1  request accepted this cycle.
- data_ok  out  1  response valid.
- data_ready  in  1  CPU accepts the response this cycle.
- rdata  out  32  response data.
- bram_en  out  1  BRAM enable.
- bram_we  out  4  BRAM byte write enables.
- bram_addr  out  ADDR_WIDTH  BRAM word address.
- bram_wdata  out  32  BRAM write data.
- bram_rdata  in  32  BRAM read data. Valid the cycle after bram_en. Held while bram_en = 0.

## Operation
- Issue: addr_ok = req && (count + pend_q < RESP_DEPTH).
  - In the issue cycle, bram_en = addr_ok.
  - bram_we = (addr_ok && wr) ? wstrb : 0.
  - bram_addr = addr[ADDR_WIDTH+1:2].
  - bram_wdata = wdata.
- size and addr[1:0] are not checked. The CPU guarantees alignment and wstrb consistency.
- pend_q: set the cycle after an issue; clear otherwise. pend_wr_q records wr for that issue.
- Response source:
  - count > 0: rdata comes from the FIFO head.
  - count == 0 and pend_q: rdata comes from the bypass path. Bypass rdata = pend_wr_q ? 0 : bram_rdata.
  - FIFO entries store the same value (0 for writes).
- data_ok = (count > 0) || pend_q.
- Pop: when data_ok && data_ready && count > 0.
- Push: when pend_q and the response is not consumed through the bypass. Bypass consumption means count == 0 && data_ready.
- A simultaneous push and pop leaves count unchanged. Order is preserved: head first, then the new entry goes to the tail.
- Pointers wrap modulo RESP_DEPTH.
- count never exceeds RESP_DEPTH. The issue rule guarantees this, even with data_ready held low indefinitely.

## Timing
- Reset values: pend_q = 0, pend_wr_q = 0, count = 0, pointers = 0.
  - Therefore data_ok = 0 and rdata = 0.
  - addr_ok, bram_en and bram_we are combinational and are 0 whenever req = 0.
- Read latency: request accepted at cycle t; data_ok = 1 with rdata = mem[word] at t+1. This is the minimum latency.
- Throughput: one request per cycle while data_ready = 1.
- Stall: with data_ready = 0, at most RESP_DEPTH responses are outstanding.
  - addr_ok drops combinationally in the cycle count + pend_q reaches RESP_DEPTH.
  - addr_ok re-asserts the cycle after the first pop.
- Read after write to the same word in consecutive cycles returns the new data. BRAM ordering guarantees this.
- Reset asserted mid-operation: all state clears immediately and asynchronously. In-flight responses are discarded. No data_ok is generated for them after reset release.

## Structure
- Shared package bridge_pkg holds:
  - size encodings SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2;
  - the default RESP_DEPTH;
  - a response-entry width constant.
- One sub-module, resp_fifo:
  - parameterised depth and width;
  - push, pop, head, count;
  - asynchronous active-low reset.
- Top level contains the issue logic, pend_q/pend_wr_q, and the bypass mux.

## Test plan
- Single read: BRAM preloaded with word 0x10 = 0xDEADBEEF; req at addr 0x40, wr = 0, data_ready = 1. Expect addr_ok at t, bram_addr = 0x10, then data_ok with rdata = 0xDEADBEEF at t+1.
- Byte write then read: write at addr 0x43, size 0, wstrb 4'b1000, wdata 0xAB000000. Expect bram_we = 4'b1000 and a write data_ok with rdata = 0. A following read of 0x40 returns 0xABADBEEF.
- Back-to-back reads of words 0..7 with data_ready = 1. Expect addr_ok every cycle and eight in-order data_ok pulses at t+1..t+8.
- Stall: data_ready = 0, four consecutive reads requested. Expect only two accepted and addr_ok = 0 until data_ready rises. Responses then drain in order, then the remaining two requests are accepted.
- Simultaneous push and pop: FIFO holds 1 entry, a new response arrives, data_ready = 1. Expect count to stay 1, the head delivered, and the next cycle to deliver the new entry.
- Reset with two responses buffered: resetn low for 1 cycle. Expect data_ok = 0 and count = 0 immediately, and no stale data_ok after release.
